rc_channel_scheduler: RTL and testbench
=======================================

// Module: rc_channel_scheduler
// PURPOSE
//  Shares one pulse-width measurement counter among NUM_CH RC servo PWM inputs in round-robin order.
//  For each enabled channel the block:
//   - waits for a clean rising edge;
//   - measures the high time in clk cycles (1 MHz clock, so 1 cycle = 1 us);
//   - classifies the result against the HIGH and LOW thresholds with hysteresis;
//   - then advances to the next channel.
//  It sits between the receiver pins (ui_in) and the switched outputs in the RC demodulator top level.
// PARAMETERS
//  NUM_CH             4      number of PWM channels; fixed at 4 (2-bit channel index)
//  MAX_COUNTER_VALUE  2000   width saturation / overrange limit, in cycles
//  HIGH_COUNTER_VALUE 1800   width >= this -> channel state 1
//  LOW_COUNTER_VALUE  1200   width <= this -> channel state 0
//  TIMEOUT_VALUE      25000  max cycles spent waiting for a rising edge
//  CNT_W              15     counter width; must hold TIMEOUT_VALUE
// PORTS
//  clk           in   1      system clock, 1 MHz
//  rst_n         in   1      reset, synchronous, active-low
//  enable_i      in   1      1 = scheduler runs; 0 = return to IDLE
//  chan_mask_i   in   4      1 = channel takes part in the rotation
//  pwm_i         in   4      raw asynchronous PWM inputs, one per channel
//  chan_state_o  out  4      classified on/off state per channel
//  chan_valid_o  out  4      1 = last measurement on that channel was good
//  width_o       out  11     last measured width, in cycles, saturated at MAX
//  width_chan_o  out  2      channel index that width_o belongs to
//  width_stb_o   out  1      one-cycle pulse when width_o/width_chan_o update
//  timeout_o     out  1      one-cycle pulse when a channel times out or is overrange
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - all outputs 0, FSM in IDLE, channel pointer 0, counter 0, synchronizers 0.
//  Input synchronization:
//   - each pwm_i bit passes through a 2-FF synchronizer; every decision below uses the synchronized value s[ch].
//  FSM states: IDLE, SELECT, WAIT_LOW, WAIT_RISE, MEASURE, EVAL.
//   - IDLE: leave to SELECT when enable_i=1 and chan_mask_i!=0; otherwise stay.
//   - SELECT (1 cycle):
//     - pointer <= next index with its mask bit set, searching ptr+1, ptr+2, ..., wrapping 3->0;
//       the current index is chosen only if it is the only masked channel;
//     - clear counter; go to WAIT_LOW.
//     - First pass after reset starts the search at index 0 inclusive.
//   - WAIT_LOW: wait for s[ptr]=0, so a pulse already in progress is never measured; then clear counter and go to WAIT_RISE.
//   - WAIT_RISE: wait for s[ptr]=1; then load counter=1 and go to MEASURE.
//   - Timeout (WAIT_LOW and WAIT_RISE):
//     - the counter increments every cycle in these states; WAIT_LOW clears it on exit, so WAIT_RISE restarts from 0;
//     - in either state, counter reaching TIMEOUT_VALUE-1 -> chan_valid_o[ptr]<=0, timeout_o pulse, go to SELECT.
//     - chan_state_o[ptr] is held on timeout.
//   - MEASURE: while s[ptr]=1, counter increments. On s[ptr]=0, go to EVAL.
//     - Result: width = number of cycles s[ptr] was high.
//     - Overrange: counter reaching MAX_COUNTER_VALUE while s[ptr] is still 1 ->
//       width_o<=MAX, width_chan_o<=ptr, width_stb_o pulse, timeout_o pulse,
//       chan_valid_o[ptr]<=0, chan_state_o[ptr] held, go to SELECT.
//   - EVAL (1 cycle), all updates in the same cycle:
//     - width_o<=counter, width_chan_o<=ptr, width_stb_o=1, chan_valid_o[ptr]<=1;
//     - width>=HIGH -> chan_state_o[ptr]<=1;
//     - width<=LOW -> chan_state_o[ptr]<=0;
//     - LOW<width<HIGH -> chan_state_o[ptr] unchanged (hysteresis);
//     - then go to SELECT.
//  Latency:
//   - width_stb_o asserts 2 cycles after s[ptr] falls (MEASURE sees the low, then EVAL);
//   - that is 4 cycles after pwm_i falls.
//  enable_i=0 in any state:
//   - next state IDLE, measurement abandoned;
//   - chan_state_o/chan_valid_o held; no strobe emitted.
//  chan_mask_i:
//   - sampled only in SELECT and IDLE;
//   - clearing the bit of the channel being measured does not abort that measurement.
//  Unmasked channels keep their last chan_state_o/chan_valid_o.
//  Reset asserted mid-measurement: on that edge, everything returns to reset values.
//  width_stb_o and timeout_o are never high for more than one consecutive cycle.
// TESTING
//  1. mask=0001; ch0 pulse 1900 us every 20 ms -> width_o=1900, width_chan_o=0, chan_state_o[0]=1, chan_valid_o[0]=1.
//  2. ch0 pulses 1000, 1500, 1900, 1500 us -> chan_state_o[0] goes 0, 0, 1, 1 (hysteresis hold on 1500).
//  3. mask=1011; all channels pulsing -> strobes on width_chan_o 0,1,3,0,1,3; channel 2 is never measured.
//  4. ch1 held low with mask=0010 -> timeout_o pulses every 25000 cycles; chan_valid_o[1]=0; chan_state_o[1] held.
//  5. ch0 held high 3000 us -> width_o=2000, width_stb_o and timeout_o pulse together, chan_valid_o[0]=0.
//  6. Assert rst_n=0 for 1 cycle mid-MEASURE (after 800 us high) -> all outputs 0 on the next cycle, no strobe, restart at ch0.

Source files
------------

// File: rtl/rc_channel_scheduler.sv
// Round-robin RC servo pulse-width scheduler: one shared counter measures the high time
// of each enabled PWM channel in turn and classifies it on/off with hysteresis.
module rc_channel_scheduler #(
   parameter int NUM_CH             = 4,
   parameter int MAX_COUNTER_VALUE  = 2000,
   parameter int HIGH_COUNTER_VALUE = 1800,
   parameter int LOW_COUNTER_VALUE  = 1200,
   parameter int TIMEOUT_VALUE      = 25000,
   parameter int CNT_W              = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic [NUM_CH-1:0] chan_mask_i,
   input  logic [NUM_CH-1:0] pwm_i,
   output logic [NUM_CH-1:0] chan_state_o,
   output logic [NUM_CH-1:0] chan_valid_o,
   output logic [10:0]       width_o,
   output logic [1:0]        width_chan_o,
   output logic              width_stb_o,
   output logic              timeout_o
);
   // state      | meaning
   // S_IDLE     | scheduler stopped, waiting for enable and a non-empty mask
   // S_SELECT   | pick next masked channel, clear counter
   // S_WAIT_LOW | wait for the selected input to be low (skip a pulse in progress)
   // S_WAIT_RISE| wait for the rising edge, timeout counting
   // S_MEASURE  | count high cycles, overrange check
   // S_EVAL     | publish width and classify
   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_WAIT_LOW, S_WAIT_RISE, S_MEASURE, S_EVAL
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_VALUE - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNTER_VALUE);
   localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(HIGH_COUNTER_VALUE);
   localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(LOW_COUNTER_VALUE);

   state_t              state_q, state_d;
   logic [NUM_CH-1:0]   sync1_q, sync2_q;
   logic [1:0]          ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                first_q, first_d;
   logic [NUM_CH-1:0]   chan_state_q, chan_state_d, chan_valid_q, chan_valid_d;
   logic [10:0]         width_q, width_d;
   logic [1:0]          width_chan_q, width_chan_d;
   logic                width_stb_q, width_stb_d, timeout_q, timeout_d;
   logic                ev_eval, ev_tmo, ev_over, s_cur;

   // First pass after reset includes the current index; later passes start one past it,
   // so the current channel only wins when it is the sole masked one.
   function automatic logic [1:0] next_ptr(input logic [1:0] cur, input logic [NUM_CH-1:0] mask,
                                           input logic incl);
      logic [1:0] res, idx, step;
      logic       found;
      res   = cur;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step = 2'(k) + (incl ? 2'd0 : 2'd1);
         idx  = cur + step;
         if (!found && mask[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   assign s_cur = sync2_q[ptr_q];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sync1_q      <= '0;
         sync2_q      <= '0;
         ptr_q        <= '0;
         cnt_q        <= '0;
         first_q      <= 1'b1;
         chan_state_q <= '0;
         chan_valid_q <= '0;
         width_q      <= '0;
         width_chan_q <= '0;
         width_stb_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= pwm_i;
         sync2_q      <= sync1_q;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         first_q      <= first_d;
         chan_state_q <= chan_state_d;
         chan_valid_q <= chan_valid_d;
         width_q      <= width_d;
         width_chan_q <= width_chan_d;
         width_stb_q  <= width_stb_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      ev_eval = 1'b0;
      ev_tmo  = 1'b0;
      ev_over = 1'b0;
      if (!enable_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (chan_mask_i != '0) state_d = S_SELECT;
            S_SELECT: begin
               if (chan_mask_i == '0) begin
                  state_d = S_IDLE;
               end else begin
                  ptr_d   = next_ptr(ptr_q, chan_mask_i, first_q);
                  first_d = 1'b0;
                  cnt_d   = '0;
                  state_d = S_WAIT_LOW;
               end
            end
            S_WAIT_LOW, S_WAIT_RISE: begin
               if ((state_q == S_WAIT_LOW) && !s_cur) begin
                  cnt_d   = '0;
                  state_d = S_WAIT_RISE;
               end else if ((state_q == S_WAIT_RISE) && s_cur) begin
                  cnt_d   = CNT_W'(1);
                  state_d = S_MEASURE;
               end else if (cnt_q == TO_LAST) begin
                  ev_tmo  = 1'b1;
                  state_d = S_SELECT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_MEASURE: begin
               if (!s_cur) begin
                  state_d = S_EVAL;
               end else if (cnt_q == CNT_MAX) begin
                  ev_over = 1'b1;
                  state_d = S_SELECT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_EVAL: begin
               ev_eval = 1'b1;
               state_d = S_SELECT;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      chan_state_d = chan_state_q;
      chan_valid_d = chan_valid_q;
      width_d      = width_q;
      width_chan_d = width_chan_q;
      width_stb_d  = 1'b0;
      timeout_d    = 1'b0;
      if (ev_tmo) begin
         chan_valid_d[ptr_q] = 1'b0;
         timeout_d           = 1'b1;
      end
      if (ev_over) begin
         width_d             = CNT_MAX[10:0];
         width_chan_d        = ptr_q;
         width_stb_d         = 1'b1;
         timeout_d           = 1'b1;
         chan_valid_d[ptr_q] = 1'b0;
      end
      if (ev_eval) begin
         width_d             = cnt_q[10:0];
         width_chan_d        = ptr_q;
         width_stb_d         = 1'b1;
         chan_valid_d[ptr_q] = 1'b1;
         if (cnt_q >= CNT_HIGH)     chan_state_d[ptr_q] = 1'b1;
         else if (cnt_q <= CNT_LOW) chan_state_d[ptr_q] = 1'b0;
      end
   end

   assign chan_state_o = chan_state_q;
   assign chan_valid_o = chan_valid_q;
   assign width_o      = width_q;
   assign width_chan_o = width_chan_q;
   assign width_stb_o  = width_stb_q;
   assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_rc_channel_scheduler.sv
// Bench for rc_channel_scheduler: fixed pulse table on ch0, timeout and reset sequences,
// then randomized pulses on a rotating target checked against a round-robin/hysteresis model.
module tb_rc_channel_scheduler;
   localparam int MAXW = 2000;
   localparam int GAP  = 20;

   logic        clk = 1'b0;
   logic        rst_n, enable;
   logic [3:0]  mask, pwm;
   logic [3:0]  chan_state_o, chan_valid_o;
   logic [10:0] width_o;
   logic [1:0]  width_chan_o;
   logic        width_stb_o, timeout_o;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int target = 0;

   typedef struct {
      int          cyc;
      logic        stb;
      logic        to;
      logic [10:0] width;
      logic [1:0]  wch;
      logic [3:0]  st;
      logic [3:0]  vl;
   } ev_t;
   ev_t evq[$];

   typedef struct {
      int   w;
      int   exp_width;
      logic exp_state;
      logic exp_valid;
      logic exp_to;
   } vec_t;
   vec_t tbl[12];

   rc_channel_scheduler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (enable),
      .chan_mask_i  (mask),
      .pwm_i        (pwm),
      .chan_state_o (chan_state_o),
      .chan_valid_o (chan_valid_o),
      .width_o      (width_o),
      .width_chan_o (width_chan_o),
      .width_stb_o  (width_stb_o),
      .timeout_o    (timeout_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic prev_stb = 1'b0, prev_to = 1'b0;
   always @(negedge clk) begin
      if (width_stb_o === 1'b1 || timeout_o === 1'b1) begin
         ev_t e;
         e.cyc = cyc; e.stb = width_stb_o; e.to = timeout_o; e.width = width_o;
         e.wch = width_chan_o; e.st = chan_state_o; e.vl = chan_valid_o;
         evq.push_back(e);
         chk("pulse_not_consecutive", {30'd0, prev_stb & width_stb_o, prev_to & timeout_o}, 0);
      end
      prev_stb = (width_stb_o === 1'b1);
      prev_to  = (timeout_o === 1'b1);
   end

   // Target channel carries the stimulus; channels outside mask|target get random noise.
   task automatic drive_cycle(input logic lvl);
      logic [3:0] tbit, noise;
      tbit  = 4'b0001 << target;
      noise = 4'($urandom) & ~(mask | tbit);
      pwm   = (lvl ? tbit : 4'b0000) | noise;
      @(posedge clk);
      #1;
   endtask

   task automatic run_pulse(input int w, output int fall_cyc);
      for (int k = 0; k < GAP; k++) drive_cycle(1'b0);
      for (int k = 0; k < w; k++) drive_cycle(1'b1);
      fall_cyc = cyc;
   endtask

   task automatic get_event(input int bound, output bit ok, output ev_t e);
      for (int k = 0; k < bound && evq.size() == 0; k++) drive_cycle(1'b0);
      ok = (evq.size() != 0);
      if (ok) e = evq.pop_front();
      else e = '{default: '0};
      chk("event_arrived", {31'd0, ok}, 1);
   endtask

   function automatic int next_masked(input int cur, input logic [3:0] m, input bit incl);
      for (int k = (incl ? 0 : 1); k <= (incl ? 3 : 4); k++)
         if (m[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive_cycle(1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   fall, t0, w, exp_w;
      bit   ok;
      ev_t  e;
      logic [3:0] m_state, m_valid;

      tbl[0]  = '{1900, 1900, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1000, 1000, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1500, 1500, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1900, 1900, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1500, 1500, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1200, 1200, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1201, 1201, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1800, 1800, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1799, 1799, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{2000, 2000, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{3000, 2000, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1,    1,    1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; enable = 1'b0; mask = 4'b0000; pwm = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_chan_state", chan_state_o, 0);
      chk("rst_chan_valid", chan_valid_o, 0);
      chk("rst_width", width_o, 0);
      chk("rst_width_chan", width_chan_o, 0);
      chk("rst_stb_to", {width_stb_o, timeout_o}, 0);
      rst_n = 1'b1;

      // Table phase: single channel 0
      mask = 4'b0001; enable = 1'b1; target = 0;
      foreach (tbl[i]) begin
         run_pulse(tbl[i].w, fall);
         get_event(40, ok, e);
         if (ok) begin
            chk("tbl_width", e.width, tbl[i].exp_width);
            chk("tbl_chan", e.wch, 0);
            chk("tbl_stb", e.stb, 1);
            chk("tbl_timeout", e.to, tbl[i].exp_to);
            chk("tbl_state0", e.st[0], tbl[i].exp_state);
            chk("tbl_valid0", e.vl[0], tbl[i].exp_valid);
            if (!tbl[i].exp_to) chk("tbl_latency", e.cyc - fall, 4);
         end
      end

      // Timeout on a channel held low, state held from a prior good pulse
      do_reset();
      mask = 4'b0010; target = 1;
      run_pulse(1900, fall);
      get_event(40, ok, e);
      t0 = e.cyc;
      if (ok) chk("to_pre_state", e.st, 4'b0010);
      get_event(26000, ok, e);
      if (ok) begin
         chk("to_flag", {e.stb, e.to}, 2'b01);
         chk("to_valid1", e.vl[1], 0);
         chk("to_state1", e.st[1], 1);
         // 1 SELECT + 1 WAIT_LOW + 25000 WAIT_RISE cycles after the strobe
         chk("to_interval", e.cyc - t0, 25002);
      end

      // Disable, retarget ch0, then reset in mid-measurement
      enable = 1'b0;
      repeat (5) drive_cycle(1'b0);
      mask = 4'b0001; target = 0; enable = 1'b1;
      run_pulse(1900, fall);
      get_event(40, ok, e);
      if (ok) begin
         chk("pre_rst_chan", e.wch, 0);
         chk("pre_rst_state", e.st, 4'b0011);
      end
      mask = 4'b0011;
      for (int k = 0; k < GAP; k++) drive_cycle(1'b0);
      for (int k = 0; k < 800; k++) drive_cycle(1'b1);
      rst_n = 1'b0;
      drive_cycle(1'b1);
      rst_n = 1'b1;
      chk("mid_rst_outputs", {chan_state_o, chan_valid_o, width_o, width_chan_o, width_stb_o, timeout_o}, 0);
      for (int k = 0; k < 200; k++) drive_cycle(1'b1);
      chk("mid_rst_no_event", evq.size(), 0);
      run_pulse(1500, fall);
      get_event(40, ok, e);
      if (ok) begin
         chk("post_rst_chan", e.wch, 0);
         chk("post_rst_width", e.width, 1500);
         chk("post_rst_valid", e.vl, 4'b0001);
      end

      // Randomized rotation against the model
      do_reset();
      m_state = '0; m_valid = '0;
      mask = 4'b1011;
      target = next_masked(0, mask, 1'b1);
      for (int r = 0; r < 18; r++) begin
         if (r >= 6) mask = 4'($urandom_range(1, 15));
         w = (r < 6) ? $urandom_range(1, 1999) : $urandom_range(1, 2300);
         exp_w = (w > MAXW) ? MAXW : w;
         run_pulse(w, fall);
         get_event(40, ok, e);
         if (ok) begin
            if (w > MAXW) m_valid[target] = 1'b0;
            else begin
               m_valid[target] = 1'b1;
               if (w >= 1800) m_state[target] = 1'b1;
               else if (w <= 1200) m_state[target] = 1'b0;
            end
            chk("rnd_chan", e.wch, target);
            chk("rnd_width", e.width, exp_w);
            chk("rnd_flags", {e.stb, e.to}, {1'b1, w > MAXW});
            chk("rnd_state", e.st, m_state);
            chk("rnd_valid", e.vl, m_valid);
            if (w <= MAXW) chk("rnd_latency", e.cyc - fall, 4);
         end
         target = next_masked(target, mask, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
